vm_switch_ctrl: RTL and testbench

- Hypervisor-side sequencer that initiates VM entry and exit. It is the driving end of the VMCS on/off interface.
- On an enter request: restores guest context through a context-memory handshake, pulses vm_on with the VMID, then waits for the VMCS to report running.
- On an exit request: saves context, pulses vm_off, then waits for running to drop.
- Sits between the privileged-instruction unit and the VMCS; reports completion, errors and the last exit reason.

---
 rtl/vm_switch_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_vm_switch_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_switch_ctrl.sv
// Hypervisor-side VM entry/exit sequencer driving the VMCS on/off interface.
// Defining VM_SWITCH_EXIT_COUNT_EN adds exit_count_o, a count of completed exit sequences.
module vm_switch_ctrl #(
   parameter int VMID_W         = 8,
   parameter int REASON_W       = 6,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enter_req_i,
   input  logic [VMID_W-1:0]   enter_vmid_i,
   input  logic                exit_req_i,
   input  logic [REASON_W-1:0] exit_reason_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [1:0]          err_code_o,
   output logic                ctx_req_o,
   output logic                ctx_save_o,
   output logic [VMID_W-1:0]   ctx_vmid_o,
   input  logic                ctx_ack_i,
   output logic                vm_on_o,
   output logic [VMID_W-1:0]   vm_vmid_o,
   output logic                vm_off_o,
   input  logic                running_i,
   input  logic [VMID_W-1:0]   current_vmid_i,
   output logic [REASON_W-1:0] last_reason_o
`ifdef VM_SWITCH_EXIT_COUNT_EN
   ,
   output logic [31:0]         exit_count_o
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_BUSY    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_RESTORE, S_ENTER, S_WAIT_RUN, S_RUN, S_SAVE, S_EXIT, S_WAIT_STOP
   } state_t;

   state_t                state_reg, state_next;
   logic [VMID_W-1:0]     vmid_reg, vmid_next;
   logic [REASON_W-1:0]   reason_reg, reason_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic                  done_reg, done_next;
   logic                  err_reg, err_next;
   logic [1:0]            code_reg, code_next;
   logic                  busy;
   logic                  timed_out;
`ifdef VM_SWITCH_EXIT_COUNT_EN
   logic                  abort_reg, abort_next;
   logic                  exit_done;
   logic [31:0]           count_reg;
`endif

   assign busy      = (state_reg != S_IDLE) && (state_reg != S_RUN);
   assign timed_out = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         vmid_reg   <= '0;
         reason_reg <= '0;
         cnt_reg    <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
         code_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         vmid_reg   <= vmid_next;
         reason_reg <= reason_next;
         cnt_reg    <= cnt_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
         code_reg   <= code_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      vmid_next   = vmid_reg;
      reason_next = reason_reg;
      cnt_next    = cnt_reg;
      done_next   = 1'b0;
      err_next    = 1'b0;
      code_next   = code_reg;
`ifdef VM_SWITCH_EXIT_COUNT_EN
      abort_next  = abort_reg;
      exit_done   = 1'b0;
`endif
      case (state_reg)
         S_IDLE: begin
            if (enter_req_i) begin
               vmid_next  = enter_vmid_i;
               cnt_next   = '0;
               state_next = S_RESTORE;
`ifdef VM_SWITCH_EXIT_COUNT_EN
               abort_next = 1'b0;
`endif
            end else if (exit_req_i) begin
               err_next  = 1'b1;
               code_next = ERR_ILLEGAL;
            end
         end
         S_RESTORE: begin
            if (ctx_ack_i) begin
               state_next = S_ENTER;
            end else if (timed_out) begin
               err_next   = 1'b1;
               code_next  = ERR_TIMEOUT;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_ENTER: begin
            cnt_next   = '0;
            state_next = S_WAIT_RUN;
         end
         S_WAIT_RUN: begin
            if (running_i && (current_vmid_i == vmid_reg)) begin
               done_next  = 1'b1;
               state_next = S_RUN;
            end else if (timed_out) begin
               // The VMCS may have half-started the guest, so force it off.
               err_next   = 1'b1;
               code_next  = ERR_TIMEOUT;
               state_next = S_EXIT;
`ifdef VM_SWITCH_EXIT_COUNT_EN
               abort_next = 1'b1;
`endif
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!running_i) begin
               err_next   = 1'b1;
               code_next  = ERR_ILLEGAL;
               state_next = S_IDLE;
            end else if (exit_req_i) begin
               reason_next = exit_reason_i;
               cnt_next    = '0;
               state_next  = S_SAVE;
`ifdef VM_SWITCH_EXIT_COUNT_EN
               abort_next  = 1'b0;
`endif
            end else if (enter_req_i) begin
               err_next  = 1'b1;
               code_next = ERR_ILLEGAL;
            end
         end
         S_SAVE: begin
            if (ctx_ack_i) begin
               state_next = S_EXIT;
            end else if (timed_out) begin
               err_next   = 1'b1;
               code_next  = ERR_TIMEOUT;
               state_next = S_EXIT;
`ifdef VM_SWITCH_EXIT_COUNT_EN
               abort_next = 1'b1;
`endif
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_EXIT: begin
            cnt_next   = '0;
            state_next = S_WAIT_STOP;
         end
         S_WAIT_STOP: begin
            if (!running_i) begin
               done_next  = 1'b1;
               state_next = S_IDLE;
`ifdef VM_SWITCH_EXIT_COUNT_EN
               exit_done  = !abort_reg;
`endif
            end else if (timed_out) begin
               err_next   = 1'b1;
               code_next  = ERR_TIMEOUT;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
      // A request in a busy state is dropped; a done/timeout report on the same cycle takes precedence.
      if (busy && (enter_req_i || exit_req_i) && !done_next && !err_next) begin
         err_next  = 1'b1;
         code_next = ERR_BUSY;
      end
   end

   always_comb begin
      busy_o        = busy;
      done_o        = done_reg;
      err_o         = err_reg;
      err_code_o    = code_reg;
      ctx_req_o     = 1'b0;
      ctx_save_o    = 1'b0;
      ctx_vmid_o    = '0;
      vm_on_o       = 1'b0;
      vm_vmid_o     = '0;
      vm_off_o      = 1'b0;
      last_reason_o = reason_reg;
      case (state_reg)
         S_RESTORE: begin
            ctx_req_o  = 1'b1;
            ctx_vmid_o = vmid_reg;
         end
         S_SAVE: begin
            ctx_req_o  = 1'b1;
            ctx_save_o = 1'b1;
            ctx_vmid_o = vmid_reg;
         end
         S_ENTER: begin
            vm_on_o   = 1'b1;
            vm_vmid_o = vmid_reg;
         end
         S_EXIT:  vm_off_o = 1'b1;
         default: ;
      endcase
   end

`ifdef VM_SWITCH_EXIT_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         abort_reg <= 1'b0;
         count_reg <= '0;
      end else begin
         abort_reg <= abort_next;
         if (exit_done) count_reg <= count_reg + 32'd1;
      end
   end

   assign exit_count_o = count_reg;
`endif

endmodule

// File: tb/tb_vm_switch_ctrl.sv
// Randomized self-checking bench for vm_switch_ctrl: a cycle-stepped VMCS/context-memory
// environment plus timeline predictions derived from request time and responder delays.
module tb_vm_switch_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       enter_req, exit_req;
   logic [7:0] enter_vmid;
   logic [5:0] exit_reason;
   logic       busy, done, err, ctx_req, ctx_save, ctx_ack, vm_on, vm_off, running;
   logic [1:0] err_code;
   logic [7:0] ctx_vmid, vm_vmid, current_vmid;
   logic [5:0] last_reason;
`ifdef VM_SWITCH_EXIT_COUNT_EN
   logic [31:0] exit_count;
`endif

   vm_switch_ctrl #(.VMID_W(8), .REASON_W(6), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .enter_req_i(enter_req), .enter_vmid_i(enter_vmid),
      .exit_req_i(exit_req), .exit_reason_i(exit_reason),
      .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
      .ctx_req_o(ctx_req), .ctx_save_o(ctx_save), .ctx_vmid_o(ctx_vmid), .ctx_ack_i(ctx_ack),
      .vm_on_o(vm_on), .vm_vmid_o(vm_vmid), .vm_off_o(vm_off),
      .running_i(running), .current_vmid_i(current_vmid),
      .last_reason_o(last_reason)
`ifdef VM_SWITCH_EXIT_COUNT_EN
      , .exit_count_o(exit_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int cyc = 0;
   // environment knobs and state
   int ack_dly = 0, run_dly = 0, stop_dly = 0;
   int req_age = -1, run_cd = -1, stop_cd = -1;
   logic [7:0] pend_vmid = 8'd0;
   // observation log for the current scenario
   int n_done, done_cyc, n_von, von_cyc, n_voff, voff_cyc, err_cyc, restore_cyc, save_cyc;
   int err_n[4];
   logic [7:0] von_vmid, seen_ctx_vmid;
   // reference state
   logic [5:0] exp_reason = 6'd0;
   int exp_exits = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_obs();
      n_done = 0; done_cyc = -1; n_von = 0; von_cyc = -1; n_voff = 0; voff_cyc = -1;
      err_cyc = -1; restore_cyc = 0; save_cyc = 0; von_vmid = 0; seen_ctx_vmid = 0;
      for (int i = 0; i < 4; i++) err_n[i] = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check("done_err_excl", done & err, 1'b0);
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) begin err_n[err_code]++; err_cyc = cyc; end
      if (vm_on) begin n_von++; von_cyc = cyc; von_vmid = vm_vmid; end
      if (vm_off) begin n_voff++; voff_cyc = cyc; end
      if (ctx_req) begin
         seen_ctx_vmid = ctx_vmid;
         if (ctx_save) save_cyc++; else restore_cyc++;
      end
      // VMCS: running follows vm_on/vm_off after the configured delays
      if (run_cd == 0) begin running = 1'b1; current_vmid = pend_vmid; run_cd = -1; end
      else if (run_cd > 0) run_cd--;
      if (stop_cd == 0) begin running = 1'b0; stop_cd = -1; end
      else if (stop_cd > 0) stop_cd--;
      if (vm_on) begin run_cd = run_dly; pend_vmid = vm_vmid; end
      if (vm_off) begin run_cd = -1; stop_cd = stop_dly; end
      // context memory acks after ctx_req has been high for ack_dly cycles
      if (ctx_req) begin req_age++; ctx_ack = (req_age >= ack_dly); end
      else begin req_age = -1; ctx_ack = 1'b0; end
   endtask

   task automatic settle();
      for (int i = 0; i < 300; i++) begin
         if (!busy) break;
         tick();
      end
      check("settle_bound", busy, 1'b0);
   endtask

   task automatic do_enter(input logic [7:0] vmid, input int a, input int r, input bit both, input bit inject);
      int t;
      ack_dly = a; run_dly = r; clear_obs();
      t = cyc;
      enter_req = 1'b1; enter_vmid = vmid; exit_req = both; exit_reason = 6'($urandom);
      tick();
      enter_req = 1'b0; exit_req = 1'b0;
      if (inject) begin
         exit_req = 1'b1; enter_req = 1'($urandom_range(0, 1));
         tick();
         exit_req = 1'b0; enter_req = 1'b0;
      end
      settle();
      $display("enter vmid=0x%0h ack_dly=%0d run_dly=%0d both=%0d inject=%0d done@%0d err@%0d",
               vmid, a, r, both, inject, done_cyc - t, err_cyc - t);
      check("enter_no_illegal", err_n[1], 0);
      check("enter_busy_errs", err_n[2], inject);
      check("enter_reason_kept", last_reason, exp_reason);
      if (a >= 64) begin
         check("restore_to_err_cyc", err_cyc, t + 65);
         check("restore_to_count", err_n[3], 1);
         check("restore_to_no_von", n_von, 0);
         check("restore_to_no_done", n_done, 0);
         check("restore_to_cycles", restore_cyc, 64);
      end else begin
         check("enter_von_count", n_von, 1);
         check("enter_von_cyc", von_cyc, t + 2 + a);
         check("enter_von_vmid", von_vmid, vmid);
         check("enter_ctx_vmid", seen_ctx_vmid, vmid);
         check("enter_restore_cycles", restore_cyc, a + 1);
         check("enter_no_save", save_cyc, 0);
         if (r >= 64) begin
            check("waitrun_to_err_cyc", err_cyc, t + 67 + a);
            check("waitrun_to_count", err_n[3], 1);
            check("waitrun_to_voff_cyc", voff_cyc, t + 67 + a);
            check("waitrun_to_done_cyc", done_cyc, t + 69 + a);
         end else begin
            check("enter_done_cyc", done_cyc, t + 4 + a + r);
            check("enter_no_timeout", err_n[3], 0);
            check("enter_no_voff", n_voff, 0);
         end
      end
   endtask

   task automatic do_exit(input logic [5:0] reason, input int a, input int s, input bit both, input bit inject);
      int t;
      ack_dly = a; stop_dly = s; clear_obs();
      t = cyc;
      exit_req = 1'b1; exit_reason = reason; enter_req = both; enter_vmid = 8'($urandom);
      tick();
      exit_req = 1'b0; enter_req = 1'b0;
      if (inject) begin
         enter_req = 1'b1;
         tick();
         enter_req = 1'b0;
      end
      settle();
      exp_reason = reason;
      $display("exit reason=0x%0h ack_dly=%0d stop_dly=%0d both=%0d inject=%0d done@%0d err@%0d",
               reason, a, s, both, inject, done_cyc - t, err_cyc - t);
      check("exit_reason", last_reason, exp_reason);
      check("exit_voff_count", n_voff, 1);
      check("exit_done_count", n_done, 1);
      check("exit_no_illegal", err_n[1], 0);
      check("exit_busy_errs", err_n[2], inject);
      if (a >= 64) begin
         check("save_to_err_cyc", err_cyc, t + 65);
         check("save_to_voff_cyc", voff_cyc, t + 65);
         check("save_to_done_cyc", done_cyc, t + 67 + s);
         check("save_to_cycles", save_cyc, 64);
      end else begin
         exp_exits++;
         check("exit_voff_cyc", voff_cyc, t + 2 + a);
         check("exit_done_cyc", done_cyc, t + 4 + a + s);
         check("exit_save_cycles", save_cyc, a + 1);
         check("exit_no_timeout", err_n[3], 0);
      end
`ifdef VM_SWITCH_EXIT_COUNT_EN
      check("exit_count", exit_count, exp_exits);
`endif
   endtask

   initial begin
      int t;
      rst = 1'b1; enter_req = 0; exit_req = 0; enter_vmid = 0; exit_reason = 0;
      ctx_ack = 0; running = 0; current_vmid = 0;
      clear_obs();
      tick(); tick();
      check("reset_ctrl", {busy, done, err, err_code, ctx_req, ctx_save, vm_on, vm_off}, 0);
      check("reset_data", {ctx_vmid, vm_vmid, last_reason}, 0);
      rst = 1'b0;
      tick();

      // exit request while idle
      clear_obs(); t = cyc;
      exit_req = 1'b1; exit_reason = 6'h3F;
      tick();
      exit_req = 1'b0;
      $display("idle exit request: err_code=%0d at +%0d", err_code, err_cyc - t);
      check("idle_exit_err_cyc", err_cyc, t + 1);
      check("idle_exit_code", err_code, 2'd1);
      check("idle_exit_reason_kept", last_reason, 6'd0);

      do_enter(8'h2A, 0, 0, 1'b0, 1'b0);
      check("run_busy", busy, 1'b0);
      do_exit(6'h11, 2, 1, 1'b0, 1'b1);
      do_enter(8'h55, 64, 0, 1'b0, 1'b0);
      do_enter(8'h13, 1, 1, 1'b1, 1'b0);
      do_exit(6'h22, 0, 0, 1'b1, 1'b0);

      // running drops while in RUN
      do_enter(8'h77, 0, 2, 1'b0, 1'b0);
      clear_obs(); t = cyc;
      running = 1'b0;
      tick();
      $display("running drop in RUN: err_code=%0d busy=%0d", err_code, busy);
      check("drop_err_cyc", err_cyc, t + 1);
      check("drop_code", err_code, 2'd1);
      check("drop_idle", busy, 1'b0);
      check("drop_no_voff", n_voff, 0);

      // reset while waiting for running
      do_enter(8'h31, 0, 0, 1'b0, 1'b0);
      do_exit(6'h05, 0, 0, 1'b0, 1'b0);
      ack_dly = 0; run_dly = 20; clear_obs();
      enter_req = 1'b1; enter_vmid = 8'h44;
      tick();
      enter_req = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      $display("reset in WAIT_RUN: busy=%0d vm_off=%0d", busy, vm_off);
      check("midreset_ctrl", {busy, done, err, err_code, ctx_req, ctx_save, vm_on, vm_off}, 0);
      check("midreset_data", {ctx_vmid, vm_vmid, last_reason}, 0);
      rst = 1'b0; run_cd = -1; running = 1'b0; exp_reason = 6'd0; exp_exits = 0;
      clear_obs();
      for (int i = 0; i < 5; i++) tick();
      check("midreset_no_voff", n_voff, 0);
      check("midreset_idle", busy, 1'b0);

      for (int it = 0; it < 24; it++) begin
         int a, r, sel;
         a = $urandom_range(0, 4); r = $urandom_range(0, 4);
         sel = $urandom_range(0, 9);
         if (sel == 0) a = 64 + $urandom_range(0, 3);
         if (sel == 1) r = 70;
         do_enter(8'($urandom), a, r, 1'($urandom_range(0, 1)), (sel > 1) && ($urandom_range(0, 2) == 0));
         if (sel > 1) begin
            int a2;
            a2 = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(0, 4);
            do_exit(6'($urandom), a2, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
